// File: rtl/dial_pkg.sv
// Shared types and the quadrature transition decoder for the rotary dial counter.
package dial_pkg;

    localparam int DIAL_COUNT_W = 8;

    typedef logic [DIAL_COUNT_W-1:0] dial_count_t;

    typedef enum logic [1:0] {
        Q00 = 2'b00,
        Q01 = 2'b01,
        Q11 = 2'b11,
        Q10 = 2'b10
    } quad_state_t;

    typedef struct packed {
        logic signed [1:0] delta;
        logic              illegal;
    } quad_step_t;

    // Position of a state along the clockwise Gray cycle 00 -> 01 -> 11 -> 10.
    function automatic logic [1:0] gray_index(input quad_state_t s);
        case (s)
            Q00:     gray_index = 2'd0;
            Q01:     gray_index = 2'd1;
            Q11:     gray_index = 2'd2;
            default: gray_index = 2'd3;
        endcase
    endfunction

    function automatic quad_step_t quad_delta(input quad_state_t prev, input quad_state_t cur);
        logic [1:0] diff;
        quad_step_t r;
        diff      = gray_index(cur) - gray_index(prev);
        r.delta   = 2'sd0;
        r.illegal = 1'b0;
        case (diff)
            2'd1:    r.delta   = 2'sd1;
            2'd3:    r.delta   = -2'sd1;
            2'd2:    r.illegal = 1'b1;
            default: r.delta   = 2'sd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dial_debounce.sv
// Two-flop synchroniser followed by a consecutive-cycle debounce filter for one dial channel.
module dial_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic filt_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync_q;
    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (sync_q == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            filt_d = sync_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin_i;
            sync_q  <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/rotary_dial_counter.sv
// Rotary dial front end: debounced quadrature decode into an 8-bit position count.
// Define DIAL_SATURATE_EN to clamp the count at 0/255 instead of wrapping modulo 256.
module rotary_dial_counter
    import dial_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter int          STEPS_PER_COUNT = 4,
    parameter dial_count_t RESET_COUNT     = 8'd0
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        dial_a,
    input  logic        dial_b,
    output dial_count_t count,
    output logic        step_pulse,
    output logic        dir,
    output logic        error_pulse
);

    localparam logic signed [3:0] STEP_POS = 4'(STEPS_PER_COUNT);
    localparam logic signed [3:0] STEP_NEG = 4'(-STEPS_PER_COUNT);

    logic              filt_a, filt_b;
    quad_state_t       cur_state;
    quad_state_t       prev_q;
    quad_step_t        qstep;
    logic signed [3:0] acc_sum;

    logic signed [2:0] acc_q, acc_d;
    dial_count_t       count_q, count_d;
    logic              dir_q, dir_d;
    logic              step_q, step_d;
    logic              err_q, err_d;

    dial_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk_i  (clk_clk),
        .rst_ni (reset_reset_n),
        .pin_i  (dial_a),
        .filt_o (filt_a)
    );

    dial_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk_i  (clk_clk),
        .rst_ni (reset_reset_n),
        .pin_i  (dial_b),
        .filt_o (filt_b)
    );

    assign cur_state = quad_state_t'({filt_a, filt_b});

    always_comb begin
        qstep   = quad_delta(prev_q, cur_state);
        // Widened by one bit so a full detent of +/-4 is representable before it clears.
        acc_sum = $signed({acc_q[2], acc_q}) + $signed({{2{qstep.delta[1]}}, qstep.delta});
        acc_d   = acc_q;
        count_d = count_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        err_d   = 1'b0;
        if (qstep.illegal) begin
            err_d = 1'b1;
        end else if (qstep.delta != 2'sd0) begin
            if (acc_sum == STEP_POS) begin
                acc_d = '0;
                dir_d = 1'b1;
`ifdef DIAL_SATURATE_EN
                if (count_q != 8'hFF) begin
                    count_d = count_q + 8'd1;
                    step_d  = 1'b1;
                end
`else
                count_d = count_q + 8'd1;
                step_d  = 1'b1;
`endif
            end else if (acc_sum == STEP_NEG) begin
                acc_d = '0;
                dir_d = 1'b0;
`ifdef DIAL_SATURATE_EN
                if (count_q != 8'h00) begin
                    count_d = count_q - 8'd1;
                    step_d  = 1'b1;
                end
`else
                count_d = count_q - 8'd1;
                step_d  = 1'b1;
`endif
            end else begin
                acc_d = acc_sum[2:0];
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            prev_q  <= Q00;
            acc_q   <= '0;
            count_q <= RESET_COUNT;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            prev_q  <= cur_state;
            acc_q   <= acc_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    assign count       = count_q;
    assign dir         = dir_q;
    assign step_pulse  = step_q;
    assign error_pulse = err_q;

endmodule

// File: tb/tb_rotary_dial_counter.sv
// Directed bench for rotary_dial_counter (DEBOUNCE_CYCLES=4, STEPS_PER_COUNT=4); honours DIAL_SATURATE_EN.
module tb_rotary_dial_counter;

    logic       clk_clk       = 1'b0;
    logic       reset_reset_n = 1'b1;
    logic       dial_a        = 1'b0;
    logic       dial_b        = 1'b0;
    logic [7:0] count;
    logic       step_pulse;
    logic       dir;
    logic       error_pulse;

    int cyc      = 0;
    int step_cnt = 0;
    int step_cyc = 0;
    int err_cnt  = 0;
    int edge_cyc = 0;
    int n_checks = 0;
    int n_pass   = 0;

    rotary_dial_counter #(
        .DEBOUNCE_CYCLES (4),
        .STEPS_PER_COUNT (4),
        .RESET_COUNT     (8'd0)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .dial_a        (dial_a),
        .dial_b        (dial_b),
        .count         (count),
        .step_pulse    (step_pulse),
        .dir           (dir),
        .error_pulse   (error_pulse)
    );

    always #5 clk_clk = ~clk_clk;

    always @(posedge clk_clk) cyc <= cyc + 1;

    always @(negedge clk_clk) begin
        if (step_pulse) begin
            step_cnt = step_cnt + 1;
            step_cyc = cyc;
        end
        if (error_pulse) err_cnt = err_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic drive_ab(input logic [1:0] ab, input int hold);
        {dial_a, dial_b} = ab;
        edge_cyc = cyc;
        tick(hold);
    endtask

    initial begin
        // Reset and idle
        #2 reset_reset_n = 1'b0;
        tick(3);
        check_eq("rst_count", count, 0);
        check_eq("rst_step", step_pulse, 0);
        check_eq("rst_dir", dir, 0);
        check_eq("rst_err", error_pulse, 0);
        reset_reset_n = 1'b1;
        drive_ab(2'b00, 20);
        check_eq("idle_count", count, 0);
        check_eq("idle_steps", step_cnt, 0);
        check_eq("idle_errs", err_cnt, 0);

        // One clockwise detent
        drive_ab(2'b01, 10);
        drive_ab(2'b11, 10);
        drive_ab(2'b10, 10);
        check_eq("cw_partial_count", count, 0);
        drive_ab(2'b00, 10);
        check_eq("cw_count", count, 1);
        check_eq("cw_dir", dir, 1);
        check_eq("cw_steps", step_cnt, 1);
        check_eq("cw_latency", step_cyc - edge_cyc, 7);

        // Three counter-clockwise detents
        for (int d = 0; d < 3; d++) begin
            drive_ab(2'b10, 10);
            drive_ab(2'b11, 10);
            drive_ab(2'b01, 10);
            drive_ab(2'b00, 10);
`ifdef DIAL_SATURATE_EN
            check_eq("ccw_count", count, 0);
`else
            check_eq("ccw_count", count, (d == 0) ? 0 : ((d == 1) ? 255 : 254));
`endif
            check_eq("ccw_dir", dir, 0);
        end
`ifdef DIAL_SATURATE_EN
        check_eq("ccw_steps", step_cnt, 2);
`else
        check_eq("ccw_steps", step_cnt, 4);
`endif

        // Short glitches on A only
        for (int g = 0; g < 5; g++) begin
            drive_ab(2'b10, 3);
            drive_ab(2'b00, 7);
        end
        tick(10);
`ifdef DIAL_SATURATE_EN
        check_eq("glitch_count", count, 0);
        check_eq("glitch_steps", step_cnt, 2);
`else
        check_eq("glitch_count", count, 254);
        check_eq("glitch_steps", step_cnt, 4);
`endif
        check_eq("glitch_errs", err_cnt, 0);

        // Illegal double-bit transitions
        drive_ab(2'b11, 10);
        check_eq("illegal_errs", err_cnt, 1);
        drive_ab(2'b00, 10);
        check_eq("illegal_errs2", err_cnt, 2);
`ifdef DIAL_SATURATE_EN
        check_eq("illegal_count", count, 0);
`else
        check_eq("illegal_count", count, 254);
`endif

        // A full detent afterwards steps exactly on its fourth edge
        drive_ab(2'b01, 10);
        drive_ab(2'b11, 10);
        drive_ab(2'b10, 10);
`ifdef DIAL_SATURATE_EN
        check_eq("post_err_partial", count, 0);
        drive_ab(2'b00, 10);
        check_eq("post_err_count", count, 1);
        check_eq("post_err_steps", step_cnt, 3);
`else
        check_eq("post_err_partial", count, 254);
        drive_ab(2'b00, 10);
        check_eq("post_err_count", count, 255);
        check_eq("post_err_steps", step_cnt, 5);
`endif
        check_eq("post_err_dir", dir, 1);

        // Half detent, reversal, then reset mid-way through the next detent
        drive_ab(2'b01, 10);
        drive_ab(2'b11, 10);
        drive_ab(2'b01, 10);
        drive_ab(2'b00, 10);
        drive_ab(2'b01, 10);
        drive_ab(2'b11, 3);
`ifdef DIAL_SATURATE_EN
        check_eq("unwind_count", count, 1);
        check_eq("unwind_steps", step_cnt, 3);
`else
        check_eq("unwind_count", count, 255);
        check_eq("unwind_steps", step_cnt, 5);
`endif
        #3 reset_reset_n = 1'b0;
        #1;
        check_eq("async_rst_count", count, 0);
        check_eq("async_rst_dir", dir, 0);
        check_eq("async_rst_step", step_pulse, 0);
        {dial_a, dial_b} = 2'b00;
        tick(3);
        reset_reset_n = 1'b1;
        tick(20);
        check_eq("post_rst_count", count, 0);
`ifdef DIAL_SATURATE_EN
        check_eq("post_rst_steps", step_cnt, 3);
`else
        check_eq("post_rst_steps", step_cnt, 5);
`endif
        check_eq("post_rst_errs", err_cnt, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
